// File: rtl/team_03_pkg.sv
// team_03_pkg: shared types and widths for the team_03 Wishbone arbiter slice.
//   arb_state_t  - arbiter FSM states
//   WB_*         - default Wishbone widths
//   CNT_W        - width of the no-ACK timeout counter (TIMEOUT <= 2^16-1)
package team_03_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int CNT_W     = 16;

  // Index width for n requesters; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/team_03_rr_pick.sv
// team_03_rr_pick: combinational round-robin pick.
//   req  in  NUM_REQ  request vector
//   ptr  in  IDX_W    index with highest priority this round
//   gnt  out NUM_REQ  one-hot grant
//   idx  out IDX_W    binary index of the grant
//   vld  out 1        any request present
module team_03_rr_pick
  import team_03_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  logic [NUM_REQ-1:0] hi;   // requests at/after ptr
  logic [NUM_REQ-1:0] pool; // candidates after wrap decision

  always_comb begin
    hi = '0;
    for (int k = 0; k < NUM_REQ; k++)
      hi[k] = req[k] && (k >= int'(ptr));
    // Nothing at/after ptr: wrap and take the lowest requester overall.
    pool = (|hi) ? hi : req;
    gnt  = '0;
    idx  = '0;
    // Descending scan so the lowest set index is the last (winning) write.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pool[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
    vld = |req;
  end

endmodule

// File: rtl/team_03_wb_arbiter.sv
// team_03_wb_arbiter: shares one Wishbone classic manager port among NUM_REQ
// requesters. Round-robin grant, one transaction at a time, no-ACK timeout.
//   clk, nrst             clock, async active-low reset
//   en                    low blocks new grants (in-flight transfer completes)
//   req/we/adr/wdat/sel   per-requester request bundle, slice i = requester i
//   rdat                  read data captured on ACK, valid in the done cycle
//   done/err              1-cycle pulse to the granted requester (ack / timeout)
//   busy                  high while in BUS or RESP
//   CYC_O..SEL_O, ACK_I, DAT_I   Wishbone classic manager signals
module team_03_wb_arbiter
  import team_03_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             en,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   adr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   wdat,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0] sel,
  output logic [DATA_W-1:0]                rdat,
  output logic [NUM_REQ-1:0]               done,
  output logic [NUM_REQ-1:0]               err,
  output logic                             busy,
  output logic                             CYC_O,
  output logic                             STB_O,
  output logic                             WE_O,
  output logic [ADDR_W-1:0]                ADR_O,
  output logic [DATA_W-1:0]                DAT_O,
  output logic [DATA_W/8-1:0]              SEL_O,
  input  logic                             ACK_I,
  input  logic [DATA_W-1:0]                DAT_I
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int SEL_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   g_q;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;

  team_03_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // One-hot AND-OR mux of the winning requester's bundle.
  logic              mux_we;
  logic [ADDR_W-1:0] mux_adr;
  logic [DATA_W-1:0] mux_wdat;
  logic [SEL_W-1:0]  mux_sel;

  always_comb begin
    mux_we   = 1'b0;
    mux_adr  = '0;
    mux_wdat = '0;
    mux_sel  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      mux_we   = mux_we   | (we[k] & pick_gnt[k]);
      mux_adr  = mux_adr  | (adr[k]  & {ADDR_W{pick_gnt[k]}});
      mux_wdat = mux_wdat | (wdat[k] & {DATA_W{pick_gnt[k]}});
      mux_sel  = mux_sel  | (sel[k]  & {SEL_W{pick_gnt[k]}});
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      ptr   <= '0;
      g_q   <= '0;
      cnt   <= '0;
      rdat  <= '0;
      done  <= '0;
      err   <= '0;
      CYC_O <= 1'b0;
      STB_O <= 1'b0;
      WE_O  <= 1'b0;
      ADR_O <= '0;
      DAT_O <= '0;
      SEL_O <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (en && pick_vld) begin
            g_q   <= pick_idx;
            WE_O  <= mux_we;
            ADR_O <= mux_adr;
            DAT_O <= mux_wdat;
            SEL_O <= mux_sel;
            CYC_O <= 1'b1;
            STB_O <= 1'b1;
            state <= BUS;
          end
        end
        BUS: begin
          cnt <= cnt + CNT_W'(1);
          // ACK is tested first so it wins over a same-cycle timeout.
          if (ACK_I) begin
            rdat      <= DAT_I;
            done[g_q] <= 1'b1;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            err[g_q]  <= 1'b1;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          ptr   <= (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_03_wb_arbiter.sv
// Directed bench for team_03_wb_arbiter (NUM_REQ=2, TIMEOUT=8).
module tb_team_03_wb_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;

  logic               clk = 1'b0;
  logic               nrst;
  logic               en;
  logic [NR-1:0]      req;
  logic [NR-1:0]      we;
  logic [NR-1:0][AW-1:0]   adr;
  logic [NR-1:0][DW-1:0]   wdat;
  logic [NR-1:0][DW/8-1:0] sel;
  logic [DW-1:0]      rdat;
  logic [NR-1:0]      done;
  logic [NR-1:0]      err;
  logic               busy;
  logic               CYC_O, STB_O, WE_O;
  logic [AW-1:0]      ADR_O;
  logic [DW-1:0]      DAT_O;
  logic [DW/8-1:0]    SEL_O;
  logic               ACK_I;
  logic [DW-1:0]      DAT_I;
  logic               ack_en;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Responder acks only while a cycle is open.
  assign ACK_I = ack_en & CYC_O & STB_O;

  team_03_wb_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .en    (en),
    .req   (req),
    .we    (we),
    .adr   (adr),
    .wdat  (wdat),
    .sel   (sel),
    .rdat  (rdat),
    .done  (done),
    .err   (err),
    .busy  (busy),
    .CYC_O (CYC_O),
    .STB_O (STB_O),
    .WE_O  (WE_O),
    .ADR_O (ADR_O),
    .DAT_O (DAT_O),
    .SEL_O (SEL_O),
    .ACK_I (ACK_I),
    .DAT_I (DAT_I)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
  endtask

  task automatic wait_cyc(input string tag);
    int n = 0;
    while (!CYC_O && n < 10) begin
      tick();
      n++;
    end
    if (!CYC_O) chk(tag, 64'(CYC_O), 64'd1);
  endtask

  initial begin
    nrst   = 1'b0;
    en     = 1'b1;
    req    = 2'b11;
    we     = '0;
    adr    = '0;
    wdat   = '0;
    sel    = '0;
    DAT_I  = '0;
    ack_en = 1'b0;

    // Reset holds everything low even with requests present.
    tick(); tick();
    chk("rst_cyc",  64'(CYC_O), 64'd0);
    chk("rst_stb",  64'(STB_O), 64'd0);
    chk("rst_done", 64'(done),  64'd0);
    chk("rst_err",  64'(err),   64'd0);
    chk("rst_busy", 64'(busy),  64'd0);
    chk("rst_rdat", 64'(rdat),  64'd0);
    chk("rst_adr",  64'(ADR_O), 64'd0);
    req  = 2'b00;
    nrst = 1'b1;
    tick();

    // Single read, ACK in third bus cycle.
    req    = 2'b01;
    adr[0] = 32'h3000_0004;
    we     = 2'b00;
    tick();
    chk("rd_cyc1", 64'(CYC_O), 64'd1);
    chk("rd_adr",  64'(ADR_O), 64'h3000_0004);
    chk("rd_we",   64'(WE_O),  64'd0);
    chk("rd_busy", 64'(busy),  64'd1);
    tick();
    chk("rd_cyc2", 64'(CYC_O), 64'd1);
    tick();
    chk("rd_cyc3", 64'(CYC_O), 64'd1);
    chk("rd_nodone", 64'(done), 64'd0);
    DAT_I  = 32'hDEAD_BEEF;
    ack_en = 1'b1;
    tick();
    chk("rd_cyc4",  64'(CYC_O), 64'd0);
    chk("rd_done",  64'(done),  64'd1);
    chk("rd_rdat",  64'(rdat),  64'hDEAD_BEEF);
    chk("rd_busyr", 64'(busy),  64'd1);
    ack_en = 1'b0;
    req    = 2'b00;
    tick();
    chk("rd_done0", 64'(done), 64'd0);
    chk("rd_idle",  64'(busy), 64'd0);

    // Fairness: both held, instant ACK, alternation from index 0.
    do_reset();
    adr[0] = A0;
    adr[1] = A1;
    DAT_I  = 32'h1234_5678;
    ack_en = 1'b1;
    req    = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_cyc("fair_wait");
      chk($sformatf("fair_adr%0d", i), 64'(ADR_O), (i % 2) ? 64'(A1) : 64'(A0));
      tick();
      chk($sformatf("fair_done%0d", i), 64'(done), (i % 2) ? 64'd2 : 64'd1);
    end
    req    = 2'b00;
    ack_en = 1'b0;
    tick();

    // Timeout: requester 1 write, never acked.
    DAT_I   = 32'hBAD0_BAD0;
    req     = 2'b10;
    we      = 2'b10;
    wdat[1] = 32'hCAFE_F00D;
    sel[1]  = 4'hC;
    tick();
    chk("to_adr", 64'(ADR_O), 64'(A1));
    chk("to_we",  64'(WE_O),  64'd1);
    chk("to_dat", 64'(DAT_O), 64'hCAFE_F00D);
    chk("to_sel", 64'(SEL_O), 64'hC);
    begin
      int n = 0;
      while (CYC_O && n < 20) begin
        n++;
        tick();
      end
      chk("to_len", 64'(n), 64'd8);
    end
    chk("to_err",  64'(err),  64'd2);
    chk("to_done", 64'(done), 64'd0);
    chk("to_rdat", 64'(rdat), 64'h1234_5678);
    req = 2'b00;
    we  = 2'b00;
    tick();
    chk("to_err0", 64'(err), 64'd0);

    // en dropped mid-bus: transfer completes, no regrant until en returns.
    req = 2'b01;
    tick();
    chk("en_cyc", 64'(CYC_O), 64'd1);
    en     = 1'b0;
    ack_en = 1'b1;
    tick();
    chk("en_done", 64'(done), 64'd1);
    ack_en = 1'b0;
    tick(); tick(); tick();
    chk("en_block", 64'(CYC_O), 64'd0);
    en = 1'b1;
    tick();
    chk("en_regrant", 64'(CYC_O), 64'd1);
    ack_en = 1'b1;
    tick();
    chk("en_done2", 64'(done), 64'd1);
    req    = 2'b00;
    ack_en = 1'b0;
    tick();

    // Reset mid-bus: pointer was 1 here; after reset index 0 wins.
    req = 2'b11;
    tick();
    chk("mr_adr1", 64'(ADR_O), 64'(A1));
    nrst = 1'b0;
    #1;
    chk("mr_cyc",  64'(CYC_O), 64'd0);
    chk("mr_stb",  64'(STB_O), 64'd0);
    chk("mr_busy", 64'(busy),  64'd0);
    tick();
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_err",  64'(err),  64'd0);
    nrst = 1'b1;
    tick();
    chk("mr_cyc2", 64'(CYC_O), 64'd1);
    chk("mr_adr0", 64'(ADR_O), 64'(A0));
    ack_en = 1'b1;
    tick();
    chk("mr_done0", 64'(done), 64'd1);
    req    = 2'b00;
    ack_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
